// File: rtl/sine_sample_streamer.sv
// Paces sample requests at the frame rate, double-buffers the returned sample and
// streams it MSB-first over bclk/fsync/sdata. Optional underrun counter: UNDERRUN_CNT_EN.
module sine_sample_streamer #(
    parameter int unsigned BIT_HALF = 4,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        sample_ready,
    input  logic [15:0] sample,
    output logic        generate_next,
    output logic        bclk,
    output logic        fsync,
    output logic        sdata,
    output logic        underrun
`ifdef UNDERRUN_CNT_EN
    ,
    output logic [7:0]  underrun_count
`endif
);

    localparam int unsigned HC_W  = (BIT_HALF > 1) ? $clog2(BIT_HALF) : 1;
    localparam int unsigned CNT_W = $clog2(32 * BIT_HALF);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [HC_W-1:0]  hcnt;
    logic [3:0]       bit_idx;
    logic [15:0]      hold_reg;
    logic [15:0]      shift_reg;
    logic [CNT_W-1:0] tcnt;

    logic             hwrap_c;
    logic             fall_c;
    logic             frame_start_c;
    logic [3:0]       bit_next_c;
    logic [CNT_W-1:0] tcnt_inc_c;
    logic             request_c;
    logic             accept_c;
    logic             expire_c;

    assign hwrap_c       = (hcnt == HC_W'(BIT_HALF - 1));
    assign fall_c        = hwrap_c & bclk;
    assign bit_next_c    = bit_idx - 4'd1;
    assign frame_start_c = fall_c & (bit_idx == 4'd0);
    assign tcnt_inc_c    = tcnt + CNT_W'(1);

    // Serial link: bit clock, bit index, frame sync and data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt      <= '0;
            bclk      <= 1'b0;
            bit_idx   <= 4'd0;
            shift_reg <= 16'd0;
            sdata     <= 1'b0;
            fsync     <= 1'b0;
        end else begin
            hcnt <= hwrap_c ? '0 : hcnt + HC_W'(1);
            if (hwrap_c) begin
                bclk <= ~bclk;
            end
            if (fall_c) begin
                bit_idx <= bit_next_c;
            end
            if (frame_start_c) begin
                shift_reg <= hold_reg;
                sdata     <= hold_reg[15];
                fsync     <= 1'b1;
            end else if (fall_c) begin
                sdata <= shift_reg[bit_next_c];
                fsync <= 1'b0;
            end
        end
    end

    // Request FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (request_c) state_d = WAIT;
            WAIT:    if (accept_c || expire_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request FSM: decoded controls; the request clk itself (tcnt==0) never accepts
    always_comb begin
        request_c = 1'b0;
        accept_c  = 1'b0;
        expire_c  = 1'b0;
        case (state_q)
            IDLE: request_c = frame_start_c & enable;
            WAIT: begin
                accept_c = sample_ready & (tcnt != '0);
                expire_c = ~accept_c & (tcnt_inc_c == CNT_W'(TIMEOUT));
            end
            default: ;
        endcase
    end

    // Handshake outputs, wait counter and capture buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            generate_next <= 1'b0;
            underrun      <= 1'b0;
            tcnt          <= '0;
            hold_reg      <= 16'd0;
        end else begin
            generate_next <= request_c;
            underrun      <= expire_c;
            if (request_c) begin
                tcnt <= '0;
            end else if (state_q == WAIT) begin
                tcnt <= tcnt_inc_c;
            end
            if (accept_c) begin
                hold_reg <= sample;
            end else if (frame_start_c && !enable) begin
                hold_reg <= 16'd0;
            end
        end
    end

`ifdef UNDERRUN_CNT_EN
    // Saturating underrun count, cleared whenever a frame starts disabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun_count <= 8'd0;
        end else if (frame_start_c && !enable) begin
            underrun_count <= 8'd0;
        end else if (expire_c && (underrun_count != 8'hFF)) begin
            underrun_count <= underrun_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sine_sample_streamer.sv
// Randomized bench for sine_sample_streamer against a time-based reference model.
module tb_sine_sample_streamer;

    localparam int BH = 4;
    localparam int TO = 64;
    localparam int FR = 32 * BH;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        sample_ready = 1'b0;
    logic [15:0] sample = 16'd0;
    logic        generate_next, bclk, fsync, sdata, underrun;
`ifdef UNDERRUN_CNT_EN
    logic [7:0]  underrun_count;
`endif

    sine_sample_streamer #(.BIT_HALF(BH), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .sample_ready  (sample_ready),
        .sample        (sample),
        .generate_next (generate_next),
        .bclk          (bclk),
        .fsync         (fsync),
        .sdata         (sdata),
        .underrun      (underrun)
`ifdef UNDERRUN_CNT_EN
        ,
        .underrun_count(underrun_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: n = clk edges since reset release
    int          n;
    int          m_req;
    int          fc;
    int          mode;
    int          resp_j;
    int          phase;
    int          m_cnt;
    bit          m_pend;
    bit          e_gen;
    bit          e_und;
    logic [15:0] m_hold;
    logic [15:0] m_word;

    task automatic model_reset();
        n = 0; m_req = -100000; fc = 0; mode = 0; m_cnt = 0;
        m_pend = 1'b0; e_gen = 1'b0; e_und = 1'b0;
        m_hold = 16'd0; m_word = 16'd0;
    endtask

    task automatic pick_mode();
        if (phase == 0) mode = (fc <= 3) ? 5 : int'($urandom_range(0, 4));
        else            mode = (fc == 1) ? 5 : 1;
        resp_j = int'($urandom_range(1, TO - 1));
    endtask

    task automatic check_outputs();
        int f;
        int idx;
        bit e_fs;
        f    = n / (2 * BH);
        idx  = (16 - (f % 16)) % 16;
        e_fs = (n >= 2 * BH) && (((n - 2 * BH) % FR) < 2 * BH);
        check("bclk",  16'(bclk),  16'((n / BH) % 2));
        check("fsync", 16'(fsync), 16'(e_fs));
        check("sdata", 16'(sdata), 16'(m_word[idx]));
        check("gen",   16'(generate_next), 16'(e_gen));
        check("underrun", 16'(underrun), 16'(e_und));
`ifdef UNDERRUN_CNT_EN
        check("ucount", 16'(underrun_count), 16'(m_cnt));
`endif
    endtask

    // Drive the responder and enable for the coming clk (j = clks since request clk)
    task automatic drive();
        int j;
        bit rdy;
        j = n - m_req;
        case (mode)
            0: rdy = (j == resp_j);
            2: rdy = (j == TO) || (j == TO + 3);
            3: rdy = (j >= 0) && (j < FR - 10);
            4: rdy = (j == 0) || (j == TO - 1);
            5: rdy = (j == 3);
            default: rdy = 1'b0;
        endcase
        if (j > TO + 5 && $urandom_range(0, 15) == 0) rdy = 1'b1;
        sample_ready = rdy;
        sample = (mode == 5) ? 16'hA5C3 : 16'($urandom);
        if (n >= 2 * BH && ((n - 2 * BH) % FR) == FR / 2) begin
            if (phase != 0)   enable = 1'b1;
            else if (fc <= 3) enable = 1'b1;
            else if (fc <= 5) enable = 1'b0;
            else              enable = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic step();
        int jj;
        @(posedge clk);
        #1;
        n++;
        e_gen = 1'b0;
        e_und = 1'b0;
        if (m_pend) begin
            jj = n - m_req - 1;
            if (jj >= 1 && sample_ready) begin
                m_hold = sample;
                m_pend = 1'b0;
            end else if (jj == TO - 1) begin
                e_und  = 1'b1;
                m_pend = 1'b0;
                if (m_cnt < 255) m_cnt++;
            end
        end
        if (n >= 2 * BH && ((n - 2 * BH) % FR) == 0) begin
            m_word = m_hold;
            fc++;
            if (enable) begin
                e_gen  = 1'b1;
                m_pend = 1'b1;
                m_req  = n;
                pick_mode();
            end else begin
                m_hold = 16'd0;
                m_cnt  = 0;
            end
        end
        check_outputs();
        drive();
    endtask

    initial begin
        int guard;
        phase = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b1;
        enable = 1'b1;
        check_outputs();
        drive();
        while (fc < 60) step();

        // Abort a pending wait with an asynchronous reset
        phase = 1;
        guard = 0;
        while (!(m_pend && mode == 1 && (n - m_req) == 40) && guard < 2000) begin
            step();
            guard++;
        end
        check("arm_reset", 16'(guard < 2000), 16'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_bclk",  16'(bclk), 16'd0);
        check("rst_sdata", 16'(sdata), 16'd0);
        check("rst_fsync", 16'(fsync), 16'd0);
        check("rst_gen",   16'(generate_next), 16'd0);
        check("rst_und",   16'(underrun), 16'd0);
`ifdef UNDERRUN_CNT_EN
        check("rst_ucount", 16'(underrun_count), 16'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        check_outputs();
        drive();
        while (fc < 262) step();
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
